alu_md_control: RTL and testbench
=================================

ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 Parameter W, default 32, operand/result width; legal range 8..64.
REQ-002 Parameter LEGACY_MULT, default 1; when 1, func 6'b100001 decodes as signed MULT.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports:
  clk        in   1   rising-edge clock
  reset      in   1   asynchronous, active-high reset
  valid_in   in   1   request present
  ready_out  out  1   block can accept a request
  alu_op     in   2   00 lw/sw, 01 beq, 10 R-type, 11 reserved
  func       in   6   R-type function field
  a, b       in   W   operands (rs, rt)
  alu_control out 4   registered ALU select
  illegal    out  1   registered: unsupported alu_op/func
  out_valid  out  1   one-cycle pulse: result/control valid
  hi, lo     out  W   multiply/divide results
  div_zero   out  1   registered: last divide had b == 0

Function
REQ-005 A request SHALL be accepted on a rising edge where valid_in and ready_out are both 1; inputs are ignored otherwise.
REQ-006 ready_out SHALL be 1 only in state IDLE.
REQ-007 Decode: alu_op 00 -> 0010; 01 -> 0011; 11 -> 1111 with illegal=1.
REQ-008 R-type func decode: 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 101010 slt 0111, 011000 mult 0100, 011001 multu 0100, 011010 div 0101, 011011 divu 0101.
REQ-009 Any other func SHALL give alu_control 1111 and illegal=1; 100001 is illegal when LEGACY_MULT=0.
REQ-010 Single-cycle ops (non-mult/div, including illegal): alu_control/illegal SHALL update at the accept edge; out_valid SHALL be 1 for exactly the next cycle; the FSM stays in IDLE.
REQ-011 FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -> MUL or DIV on accept.
  - MUL/DIV -> FIX after W iteration cycles.
  - FIX -> DONE.
  - DONE -> IDLE.
REQ-012 MUL: shift-add over operand magnitudes, one bit per cycle; signed variants negate the 2W-bit product in FIX when sign(a) xor sign(b).
REQ-013 DIV: restoring, one quotient bit per cycle on magnitudes; in FIX, lo=quotient and hi=remainder are sign-corrected (quotient sign = sign(a) xor sign(b); remainder sign = sign(a)).
REQ-014 Mult/div latency: out_valid SHALL be high in the cycle W+2 edges after the accept edge; hi/lo are valid from then and held until the next mult/div completes.
REQ-015 Divide by zero: DIV SHALL go directly to FIX after one cycle; results SHALL be lo = all ones and hi = a; div_zero=1. div_zero SHALL be cleared by any later successful divide.
REQ-016 Most-negative operands SHALL be handled without overflow (W+1-bit internal magnitude); signed -2^(W-1)/-1 SHALL give lo = -2^(W-1), hi = 0.
REQ-017 alu_control/illegal SHALL hold their last value between requests; no combinational path from inputs to outputs.

Reset
REQ-018 Asserting reset at any time, including mid-iteration, SHALL immediately force:
  - state IDLE, ready_out=1
  - alu_control=0000, illegal=0, out_valid=0, div_zero=0
  - hi=0, lo=0
  - iteration counter=0
REQ-019 An aborted operation SHALL produce no out_valid after reset deasserts.

Structure
REQ-020 A shared package SHALL hold the alu_control encodings, the func/alu_op constants and the FSM state enum.
REQ-021 The iterative datapath SHALL be one sub-module, muldiv_iter (operand/remainder registers, counter, sign fix), controlled by alu_md_control.

Verification
REQ-022 add: alu_op=10, func=100000 -> alu_control=0010, out_valid 1 cycle later, ready_out stays 1.
REQ-023 W=32 mult, a=-3, b=7 -> out_valid at accept+34, {hi,lo}=64'hFFFFFFFF_FFFFFFEB; ready_out=0 throughout.
REQ-024 divu a=100, b=7 -> lo=14, hi=2; div a=-7, b=2 -> lo=-3, hi=-1.
REQ-025 div b=0, a=5 -> lo=32'hFFFFFFFF, hi=5, div_zero=1.
REQ-026 func=111111 -> alu_control=1111, illegal=1; with LEGACY_MULT=0, func=100001 -> illegal=1.
REQ-027 Reset asserted at iteration 10 of a mult -> outputs zero immediately, ready_out=1, no out_valid afterwards; a valid_in held high during MUL is not accepted until IDLE.

Source files
------------

// File: rtl/alu_md_control_pkg.sv
// Shared encodings for the ALU control decoder and its iterative mult/div engine.
// Holds the alu_control codes, alu_op/func constants, FSM states and the decode helper.
package alu_md_control_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_BEQ = 4'b0011;
  localparam logic [3:0] CTL_MUL = 4'b0100;
  localparam logic [3:0] CTL_DIV = 4'b0101;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_ILL = 4'b1111;

  localparam logic [1:0] OP_MEM   = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [5:0] FN_ADD         = 6'b100000;
  localparam logic [5:0] FN_LEGACY_MULT = 6'b100001;
  localparam logic [5:0] FN_SUB         = 6'b100010;
  localparam logic [5:0] FN_AND         = 6'b100100;
  localparam logic [5:0] FN_OR          = 6'b100101;
  localparam logic [5:0] FN_SLT         = 6'b101010;
  localparam logic [5:0] FN_MULT        = 6'b011000;
  localparam logic [5:0] FN_MULTU       = 6'b011001;
  localparam logic [5:0] FN_DIV         = 6'b011010;
  localparam logic [5:0] FN_DIVU        = 6'b011011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] ctl;
    logic       illegal;
    logic       is_mul;
    logic       is_div;
    logic       is_signed;
  } decode_t;

  function automatic decode_t decode(input logic [1:0] alu_op, input logic [5:0] func,
                                     input logic legacy_mult);
    decode_t d;
    d = '{ctl: CTL_ILL, illegal: 1'b1, is_mul: 1'b0, is_div: 1'b0, is_signed: 1'b0};
    case (alu_op)
      OP_MEM: begin d.ctl = CTL_ADD; d.illegal = 1'b0; end
      OP_BEQ: begin d.ctl = CTL_BEQ; d.illegal = 1'b0; end
      OP_RTYPE: begin
        d.illegal = 1'b0;
        case (func)
          FN_ADD:   d.ctl = CTL_ADD;
          FN_SUB:   d.ctl = CTL_SUB;
          FN_AND:   d.ctl = CTL_AND;
          FN_OR:    d.ctl = CTL_OR;
          FN_SLT:   d.ctl = CTL_SLT;
          FN_MULT:  begin d.ctl = CTL_MUL; d.is_mul = 1'b1; d.is_signed = 1'b1; end
          FN_MULTU: begin d.ctl = CTL_MUL; d.is_mul = 1'b1; end
          FN_DIV:   begin d.ctl = CTL_DIV; d.is_div = 1'b1; d.is_signed = 1'b1; end
          FN_DIVU:  begin d.ctl = CTL_DIV; d.is_div = 1'b1; end
          FN_LEGACY_MULT: begin
            if (legacy_mult) begin
              d.ctl = CTL_MUL; d.is_mul = 1'b1; d.is_signed = 1'b1;
            end else begin
              d.illegal = 1'b1;
            end
          end
          default:  d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_md_control_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes.
// Sign correction happens in the fix step; hi/lo/div_zero only change on commit.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_div,
  input  logic         op_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         step,
  input  logic         fix,
  input  logic         commit,
  output logic         last,
  output logic         b_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_zero
);
  localparam int CW = $clog2(W) + 1;

  logic [W:0]     acc;
  logic [W-1:0]   quo;
  logic [W:0]     dvs;
  logic [W-1:0]   a_keep;
  logic           neg_q, neg_r, is_div;
  logic [CW-1:0]  cnt;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic [W+1:0]   sum;
  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic           ge;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   q_fix, r_fix;

  // -2^(W-1) negates to 2^(W-1), which is still exact as an unsigned W-bit magnitude.
  assign a_neg = op_signed & a[W-1];
  assign b_neg = op_signed & b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign sum      = {1'b0, acc} + (quo[0] ? {1'b0, dvs} : '0);
  assign shifted  = {acc[W-1:0], quo[W-1]};
  assign diff     = {1'b0, shifted} - {1'b0, dvs};
  assign ge       = ~diff[W+1];
  assign prod     = {acc[W-1:0], quo};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -quo : quo;
  assign r_fix    = neg_r ? -acc[W-1:0] : acc[W-1:0];

  assign last   = step & (cnt == CW'(W - 1));
  assign b_zero = is_div & (dvs == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; quo <= '0; dvs <= '0; a_keep <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; is_div <= 1'b0; cnt <= '0;
      hi <= '0; lo <= '0; div_zero <= 1'b0;
    end else begin
      if (start) begin
        acc    <= '0;
        quo    <= a_mag;
        dvs    <= {1'b0, b_mag};
        a_keep <= a;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        is_div <= op_div;
        cnt    <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          acc <= ge ? diff[W:0] : shifted;
          quo <= {quo[W-2:0], ge};
        end else begin
          acc <= sum[W+1:1];
          quo <= {sum[0], quo[W-1:1]};
        end
      end else if (fix) begin
        if (is_div && b_zero) begin
          acc <= {1'b0, a_keep};
          quo <= '1;
        end else if (is_div) begin
          acc <= {1'b0, r_fix};
          quo <= q_fix;
        end else begin
          {acc, quo} <= {1'b0, prod_fix};
        end
      end
      if (commit) begin
        hi <= acc[W-1:0];
        lo <= quo;
        if (is_div) div_zero <= b_zero;
      end
    end
  end

endmodule

// File: rtl/alu_md_control.sv
// ALU control decoder: single-cycle ops answer in one cycle, mult/div run through muldiv_iter.
// Handshake: a request is taken on a rising edge with valid_in && ready_out; out_valid pulses once per result.
module alu_md_control
  import alu_md_control_pkg::*;
#(
  parameter int W           = 32,
  parameter int LEGACY_MULT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [1:0]   alu_op,
  input  logic [5:0]   func,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [3:0]   alu_control,
  output logic         illegal,
  output logic         out_valid,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         div_zero
);
  state_t  state, state_nx;
  decode_t dec;
  logic    accept, start_md, step, fix, commit, last, b_zero;

  assign dec      = decode(alu_op, func, LEGACY_MULT != 0);
  assign accept   = valid_in & ready_out;
  assign start_md = accept & (dec.is_mul | dec.is_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_md) state_nx = dec.is_div ? ST_DIV : ST_MUL;
      ST_MUL:  if (last) state_nx = ST_FIX;
      ST_DIV:  if (b_zero || last) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == ST_IDLE);
    step      = (state == ST_MUL) || (state == ST_DIV);
    fix       = (state == ST_FIX);
    commit    = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_control <= 4'b0000;
      illegal     <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= (accept & ~(dec.is_mul | dec.is_div)) | commit;
      if (accept) begin
        alu_control <= dec.ctl;
        illegal     <= dec.illegal;
      end
    end
  end

  muldiv_iter #(.W(W)) u_iter (
    .clk       (clk),
    .rst       (reset),
    .start     (start_md),
    .op_div    (dec.is_div),
    .op_signed (dec.is_signed),
    .a         (a),
    .b         (b),
    .step      (step),
    .fix       (fix),
    .commit    (commit),
    .last      (last),
    .b_zero    (b_zero),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

endmodule

// File: tb/tb_alu_md_control.sv
// Bench for alu_md_control: directed requests push expected responses, a monitor pops on out_valid.
module tb_alu_md_control;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in, ready_out;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic [3:0]   alu_control;
  logic         illegal, out_valid, div_zero;
  logic [W-1:0] hi, lo;

  logic         valid2, ready2, illegal2, out_valid2, div_zero2;
  logic [1:0]   alu_op2;
  logic [5:0]   func2;
  logic [3:0]   alu_control2;
  logic [W-1:0] hi2, lo2;

  typedef struct packed {
    logic [3:0]   ctl;
    logic         ill;
    logic         md;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic [31:0]  cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu_md_control #(.W(W), .LEGACY_MULT(1)) u_dut (
    .clk(clk), .reset(rst), .valid_in(valid_in), .ready_out(ready_out),
    .alu_op(alu_op), .func(func), .a(a), .b(b), .alu_control(alu_control),
    .illegal(illegal), .out_valid(out_valid), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  alu_md_control #(.W(W), .LEGACY_MULT(0)) u_dut_nl (
    .clk(clk), .reset(rst), .valid_in(valid2), .ready_out(ready2),
    .alu_op(alu_op2), .func(func2), .a('0), .b('0), .alu_control(alu_control2),
    .illegal(illegal2), .out_valid(out_valid2), .hi(hi2), .lo(lo2), .div_zero(div_zero2)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("alu_control", 64'(alu_control), 64'(mon_e.ctl));
        chk("illegal", 64'(illegal), 64'(mon_e.ill));
        chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
        if (mon_e.md) begin
          chk("hi", 64'(hi), 64'(mon_e.hi));
          chk("lo", 64'(lo), 64'(mon_e.lo));
          chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [3:0] ctl, input logic ill,
                       input int lat, input logic md, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edz, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    alu_op = op; func = fn; a = av; b = bv; valid_in = 1'b1;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=busy required=ready");
      valid_in = 1'b0;
      acc_cyc = cyc;
    end else begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      acc_cyc = cyc;
      exp_q.push_back('{ctl: ctl, ill: ill, md: md, hi: ehi, lo: elo, dz: edz,
                        cyc: 32'(acc_cyc + lat)});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL response_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic sc(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] ctl,
                    input logic ill);
    int c;
    issue(op, fn, '0, '0, ctl, ill, 0, 1'b0, '0, '0, 1'b0, c);
  endtask

  task automatic md(input logic [5:0] fn, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic [3:0] ctl, input int lat, input logic [W-1:0] ehi,
                    input logic [W-1:0] elo, input logic edz);
    int c;
    issue(2'b10, fn, av, bv, ctl, 1'b0, lat, 1'b1, ehi, elo, edz, c);
    if (lat > 12) begin
      repeat (10) @(negedge clk);
      chk("ready_busy", 64'(ready_out), 64'd0);
    end
    drain();
  endtask

  int c0;
  int n;
  int seen_ov;

  initial begin
    rst = 1'b1; valid_in = 1'b0; alu_op = '0; func = '0; a = '0; b = '0;
    valid2 = 1'b0; alu_op2 = '0; func2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-cycle decode
    sc(2'b10, 6'b100000, 4'b0010, 1'b0);
    chk("ready_after_add", 64'(ready_out), 64'd1);
    sc(2'b00, 6'b000000, 4'b0010, 1'b0);
    sc(2'b01, 6'b000000, 4'b0011, 1'b0);
    sc(2'b11, 6'b100000, 4'b1111, 1'b1);
    sc(2'b10, 6'b100010, 4'b0110, 1'b0);
    sc(2'b10, 6'b100100, 4'b0000, 1'b0);
    sc(2'b10, 6'b100101, 4'b0001, 1'b0);
    sc(2'b10, 6'b101010, 4'b0111, 1'b0);
    sc(2'b10, 6'b111111, 4'b1111, 1'b1);
    drain();
    chk("ctl_held", 64'(alu_control), 64'b1111);
    chk("illegal_held", 64'(illegal), 64'd1);

    // multiply / divide
    md(6'b011000, 32'hFFFFFFFD, 32'd7, 4'b0100, W + 2, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    md(6'b011001, 32'hFFFFFFFF, 32'd2, 4'b0100, W + 2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    md(6'b011011, 32'd100, 32'd7, 4'b0101, W + 2, 32'd2, 32'd14, 1'b0);
    md(6'b011010, 32'hFFFFFFF9, 32'd2, 4'b0101, W + 2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    md(6'b011010, 32'd5, 32'd0, 4'b0101, 3, 32'd5, 32'hFFFFFFFF, 1'b1);
    md(6'b011011, 32'd9, 32'd3, 4'b0101, W + 2, 32'd0, 32'd3, 1'b0);
    md(6'b011010, 32'h80000000, 32'hFFFFFFFF, 4'b0101, W + 2, 32'd0, 32'h80000000, 1'b0);
    md(6'b011000, 32'h80000000, 32'h80000000, 4'b0100, W + 2, 32'h40000000, 32'h0, 1'b0);
    md(6'b100001, 32'hFFFFFFFE, 32'd3, 4'b0100, W + 2, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    md(6'b011010, 32'd9, 32'd0, 4'b0101, 3, 32'd9, 32'hFFFFFFFF, 1'b1);

    // valid_in held high through a multiply is taken only once back in IDLE
    issue(2'b10, 6'b011001, 32'd3, 32'd5, 4'b0100, 1'b0, W + 2, 1'b1, 32'd0, 32'd15, 1'b1, c0);
    alu_op = 2'b10; func = 6'b100000; valid_in = 1'b1;
    exp_q.push_back('{ctl: 4'b0010, ill: 1'b0, md: 1'b0, hi: '0, lo: '0, dz: 1'b0,
                      cyc: 32'(c0 + W + 3)});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cyc < c0 + W + 3 && n < 100);
    valid_in = 1'b0;
    drain();
    chk("lo_held_after_add", 64'(lo), 64'd15);
    chk("div_zero_held_after_mult", 64'(div_zero), 64'd1);

    // reset in the middle of a multiply
    issue(2'b10, 6'b011001, 32'd6, 32'd7, 4'b0100, 1'b0, W + 2, 1'b1, 32'd0, 32'd42, 1'b1, c0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_ready", 64'(ready_out), 64'd1);
    chk("abort_alu_control", 64'(alu_control), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_div_zero", 64'(div_zero), 64'd0);
    chk("abort_counter", 64'(u_dut.u_iter.cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_ov = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen_ov++;
    end
    chk("no_out_valid_after_abort", 64'(seen_ov), 64'd0);
    sc(2'b01, 6'b000000, 4'b0011, 1'b0);
    drain();

    // LEGACY_MULT=0 instance: 100001 is illegal
    @(negedge clk);
    alu_op2 = 2'b10; func2 = 6'b100001; valid2 = 1'b1;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    chk("nolegacy_ctl", 64'(alu_control2), 64'b1111);
    chk("nolegacy_illegal", 64'(illegal2), 64'd1);
    @(negedge clk);
    chk("nolegacy_out_valid", 64'(out_valid2), 64'd1);
    chk("nolegacy_ready", 64'(ready2), 64'd1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
